cdc_src_rr_mux: RTL and testbench
=================================

# cdc_src_rr_mux

Round-robin burst-locking multiplexer that shares the source side of one `cdc_fifo_gray` between `NumIn` requesters in the source clock domain. It arbitrates valid/ready streams and registers the winner's payload together with its requester index. The registered output connects directly to `src_data_i`/`src_valid_i`/`src_ready_o` of the FIFO. The destination side can demultiplex on the carried index.

## Interface
Parameters:
- `NumIn`, 4: number of requesters; ≥2.
- `WIDTH`, 32: payload width per requester.
- `MaxBurst`, 4: maximum consecutive beats granted to one requester before forced rotation; ≥1.
- `IdxWidth`, `$clog2(NumIn)`: derived; do not override.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1: source-domain clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `in_data_i`  in  NumIn×WIDTH: per-requester payload.
- `in_valid_i`  in  NumIn: per-requester valid.
- `in_ready_o`  out  NumIn: per-requester ready; one-hot or zero.
- `out_data_o`  out  WIDTH: registered payload, to FIFO `src_data_i` (low bits).
- `out_idx_o`  out  IdxWidth: registered requester index, to FIFO `src_data_i` (high bits).
- `out_valid_o`  out  1: to FIFO `src_valid_i`.
- `out_ready_i`  in  1: from FIFO `src_ready_o`.

## Operation
- State registers:
  - `rr_q` (IdxWidth): priority pointer.
  - `gnt_q` (IdxWidth): current grant.
  - `lock_q` (1): grant locked.
  - `cnt_q` (`$clog2(MaxBurst+1)`): beats in current burst.
  - Output register: `out_data`, `out_idx`, `out_valid`.
- Stage accept: `accept = !out_valid_q | out_ready_i`.
- Grant selection:
  - If `lock_q`, the selected requester is `gnt_q`.
  - Otherwise it is the first index `i` with `in_valid_i[i]`, scanning `rr_q, rr_q+1, …, NumIn-1, 0, …` with wrap modulo `NumIn`.
- Ready: `in_ready_o[sel] = accept & in_valid_i[sel]`. All other ready bits are 0. Ready never asserts for an idle requester.
- On handshake (`in_valid_i[sel] & in_ready_o[sel]`):
  - Load the output register with `in_data_i[sel]` and `sel`; set `out_valid`.
  - Increment `cnt_q`.
  - If `cnt_q+1 == MaxBurst`:
    - Clear `lock_q` and `cnt_q`.
    - Set `rr_q = (sel+1) mod NumIn`.
  - Otherwise set `lock_q=1` and `gnt_q=sel`.
- Lock release without handshake: if `lock_q` is set and `in_valid_i[gnt_q]` is low, then in the same cycle:
  - Clear `lock_q` and `cnt_q`.
  - Set `rr_q = (gnt_q+1) mod NumIn`.
  - Perform selection from the unlocked scan, so no bubble is inserted.
- Output drain: if `out_ready_i` is high and no handshake occurs, clear `out_valid`.
- Requester contract:
  - A requester must not drop valid or change data while not ready (AXI-stream rule).
  - The block itself never retracts `out_valid_o` or changes `out_data_o`/`out_idx_o` while `out_valid_o & !out_ready_i`.
- Wrap-around: `rr_q` wraps from `NumIn-1` to 0. For non-power-of-two `NumIn`, `rr_q` must never hold a value ≥ `NumIn`.

## Timing
- Reset values:
  - `out_valid_o=0`, `out_data_o=0`, `out_idx_o=0`.
  - `in_ready_o=0` combinationally while all valids are low.
  - `rr_q=0`, `gnt_q=0`, `lock_q=0`, `cnt_q=0`.
- Reset asserted mid-burst discards the held beat and the lock immediately (asynchronous). The first grant after deassertion goes to the lowest valid index.
- Latency is 1 cycle from input handshake to `out_valid_o`.
- Throughput is 1 beat/cycle while `out_ready_i` stays high.
- Combinational paths:
  - `out_ready_i` → `in_ready_o` (one gate level plus selection).
  - `in_valid_i` → `in_ready_o`.
  - No path from `in_data_i` to any output.
- Backpressure: while FIFO-full holds `out_ready_i` low, `cnt_q` and `lock_q` are frozen, and the burst continues once space frees.

## Structure
- No package needed.
- The payload is `WIDTH+IdxWidth` bits; the instantiating parent sets the FIFO `WIDTH` accordingly.
- Sub-module: `lzc` (common_cells leading-zero counter) performs the rotated priority pick. The valid vector is rotated by `rr_q`, the trailing-zero count is taken, and `rr_q` is added back modulo `NumIn`.
- All flops use the common_cells register macros with asynchronous active-high reset.

## Test plan
- **Single requester.** Setup: `NumIn=4`, `MaxBurst=4`, requester 2 sends 10 beats `0x100..0x109`, `out_ready_i=1`. Required: the output carries all 10 beats in order with idx 2 at 1 beat/cycle, and `rr_q` ends at 3.
- **Burst fairness.** Setup: requesters 0 and 1 continuously valid. Required: output idx sequence is 0,0,0,0,1,1,1,1,0,… with no gap cycles.
- **Early release.** Setup: requester 3 sends 2 beats then drops valid while requester 0 is valid. Required: requester 0 is granted the very next cycle, and `rr_q` becomes 0 after the wrap from 3.
- **Backpressure.** Setup: hold `out_ready_i=0` for 5 cycles mid-burst. Required:
  - `out_data_o`/`out_idx_o` are stable and `out_valid_o=1`.
  - All `in_ready_o=0`.
  - On release, the burst resumes with the remaining beat count.
- **Reset mid-burst.** Setup: assert `rst_i` asynchronously with a beat held. Required: `out_valid_o` falls without a clock edge, and after release requester 0 (lowest valid) wins.
- **Randomized scoreboard.** Setup: run against a `cdc_fifo_gray` with `NumIn=3` (non-power-of-two). Required: per-index order is preserved, no loss or duplication, and no requester waits more than `(NumIn-1)·MaxBurst` accepted beats.

Source files
------------

// File: rtl/cdc_src_rr_mux_pkg.sv
// cdc_src_rr_mux_pkg
//   Shared helpers for the round-robin source-side mux.
//   wrap_add : (a + b) mod n for operands already below n. It needs no divider,
//              which keeps index arithmetic cheap for non-power-of-two counts.
package cdc_src_rr_mux_pkg;

    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/cdc_src_rr_mux_lzc.sv
// cdc_src_rr_mux_lzc
//   Trailing-zero counter, used for the rotated priority pick.
//   Ports:
//     in_i    : vector to scan, bit 0 has the highest priority
//     cnt_o   : index of the lowest set bit (0 when the vector is empty)
//     empty_o : no bit set
module cdc_src_rr_mux_lzc #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CntWidth = 2
) (
    input  logic [WIDTH-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CntWidth'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/cdc_src_rr_mux.sv
// cdc_src_rr_mux
//   Round-robin, burst-locking mux that shares one FIFO source port between
//   NumIn valid/ready requesters. The winner's payload and index are registered
//   and presented to the FIFO. A requester keeps the grant for up to MaxBurst
//   consecutive beats, or until it drops valid. After that the priority pointer
//   moves to the requester after it.
//
//   Handshake: a beat transfers on a cycle where valid and ready are both high.
//   A source must hold valid and data until ready. This block never retracts
//   out_valid_o or changes out_data_o/out_idx_o while out_ready_i is low.
//
//   Ports:
//     clk_i       : source-domain clock
//     rst_i       : asynchronous active-high reset
//     in_data_i   : per-requester payload
//     in_valid_i  : per-requester valid
//     in_ready_o  : per-requester ready, one-hot or zero
//     out_data_o  : registered payload (FIFO data low bits)
//     out_idx_o   : registered requester index (FIFO data high bits)
//     out_valid_o : to FIFO src_valid_i
//     out_ready_i : from FIFO src_ready_o
module cdc_src_rr_mux
    import cdc_src_rr_mux_pkg::*;
#(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MaxBurst = 4,
    parameter int unsigned IdxWidth = $clog2(NumIn)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumIn-1:0][WIDTH-1:0] in_data_i,
    input  logic [NumIn-1:0]            in_valid_i,
    output logic [NumIn-1:0]            in_ready_o,
    output logic [WIDTH-1:0]            out_data_o,
    output logic [IdxWidth-1:0]         out_idx_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);

    localparam int unsigned CntWidth = $clog2(MaxBurst + 1);

    logic [IdxWidth-1:0] r_rr;
    logic [IdxWidth-1:0] r_gnt;
    logic                r_lock;
    logic [CntWidth-1:0] r_cnt;
    logic [WIDTH-1:0]    r_out_data;
    logic [IdxWidth-1:0] r_out_idx;
    logic                r_out_valid;

    logic                w_accept;
    logic                w_release;
    logic                w_held;
    logic [IdxWidth-1:0] w_rr_eff;
    logic [CntWidth-1:0] w_cnt_eff;
    logic [NumIn-1:0]    w_rot;
    logic [IdxWidth-1:0] w_tz;
    logic                w_empty;
    logic [IdxWidth-1:0] w_scan_sel;
    logic [IdxWidth-1:0] w_sel;
    logic [IdxWidth-1:0] w_sel_next;
    logic                w_hs;
    logic                w_last;

    // The output stage can take a new beat when it is empty or draining.
    assign w_accept = ~r_out_valid | out_ready_i;

    // A locked requester that dropped valid gives up the grant in this same
    // cycle. The scan then restarts after it, so no bubble cycle is inserted.
    assign w_release = r_lock & ~in_valid_i[r_gnt];
    assign w_held    = r_lock & ~w_release;
    assign w_rr_eff  = w_release ? IdxWidth'(wrap_add(32'(r_gnt), 32'd1, NumIn)) : r_rr;
    assign w_cnt_eff = w_release ? '0 : r_cnt;

    // Rotate valids so that the pointer position lands on bit 0.
    always_comb begin
        w_rot = '0;
        for (int unsigned j = 0; j < NumIn; j++) begin
            w_rot[j] = in_valid_i[IdxWidth'(wrap_add(j, 32'(w_rr_eff), NumIn))];
        end
    end

    cdc_src_rr_mux_lzc #(
        .WIDTH    (NumIn),
        .CntWidth (IdxWidth)
    ) u_lzc (
        .in_i    (w_rot),
        .cnt_o   (w_tz),
        .empty_o (w_empty)
    );

    // Undo the rotation. The wrap keeps the index below NumIn.
    assign w_scan_sel = IdxWidth'(wrap_add(32'(w_tz), 32'(w_rr_eff), NumIn));
    assign w_sel      = w_held ? r_gnt : w_scan_sel;
    assign w_sel_next = IdxWidth'(wrap_add(32'(w_sel), 32'd1, NumIn));
    assign w_hs       = w_accept & (w_held | ~w_empty);
    assign w_last     = (w_cnt_eff == CntWidth'(MaxBurst - 1));

    always_comb begin
        in_ready_o = '0;
        if (w_hs) begin
            in_ready_o[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr        <= '0;
            r_gnt       <= '0;
            r_lock      <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_hs) begin
                r_out_data  <= in_data_i[w_sel];
                r_out_idx   <= w_sel;
                r_out_valid <= 1'b1;
                if (w_last) begin
                    // Burst exhausted: force rotation past the winner.
                    r_lock <= 1'b0;
                    r_cnt  <= '0;
                    r_rr   <= w_sel_next;
                end else begin
                    r_lock <= 1'b1;
                    r_gnt  <= w_sel;
                    r_cnt  <= w_cnt_eff + CntWidth'(1);
                    r_rr   <= w_rr_eff;
                end
            end else begin
                if (w_release) begin
                    r_lock <= 1'b0;
                    r_cnt  <= '0;
                    r_rr   <= w_rr_eff;
                end
                if (out_ready_i) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_data_o  = r_out_data;
    assign out_idx_o   = r_out_idx;
    assign out_valid_o = r_out_valid;

endmodule

// File: tb/tb_cdc_src_rr_mux.sv
// tb_cdc_src_rr_mux
//   Bench for cdc_src_rr_mux with NumIn=3 (non-power-of-two), MaxBurst=4.
//   A cycle-level reference model predicts ready, the output register and the
//   priority pointer from the arbitration rules. Per-index queues track every
//   accepted beat, and hand-written literal sequences pin the directed
//   scenarios.
module tb_cdc_src_rr_mux;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int MB = 4;

    logic               clk;
    logic               rst;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [W-1:0]       out_data;
    logic [1:0]         out_idx;
    logic               out_valid;
    logic               out_ready;

    cdc_src_rr_mux #(
        .NumIn    (N),
        .WIDTH    (W),
        .MaxBurst (MB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Drivers: beats left to send, start delay, next payload.
    int         src_left [N];
    int         src_delay[N];
    logic [W-1:0] src_data[N];
    bit         rand_mode = 1'b0;
    bit         bp_check  = 1'b0;

    // Reference model: pointer, owner (-1 = none), beats in burst, output reg.
    int         m_ptr;
    int         m_owner;
    int         m_beats;
    bit         m_ov;
    logic [W-1:0] m_od;
    int         m_oi;
    // Model combinational view of the current cycle.
    int         c_start;
    int         c_owner;
    int         c_beats;
    int         e_sel;
    bit         e_hs;
    logic [N-1:0] e_ready;
    logic [N-1:0] s_ready;

    // Scoreboard and observation log.
    logic [W-1:0] exp_q[N][$];
    int         obs_idx[$];
    logic [W-1:0] obs_data[$];
    int         obs_cyc[$];
    int         wait_cnt[N];
    int         max_wait;

    int         t2_exp[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int         t4_idx[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int         t4_dat[10] = '{'h400, 'h401, 'h402, 'h403, 'h500, 'h501, 'h502, 'h503, 'h404, 'h405};
    int         t5_idx[4]  = '{0, 0, 2, 2};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void clear_bench();
        for (int i = 0; i < N; i++) begin
            src_left[i]  = 0;
            src_delay[i] = 0;
            src_data[i]  = W'(i << 12);
            wait_cnt[i]  = 0;
            exp_q[i].delete();
        end
        m_ptr = 0; m_owner = -1; m_beats = 0; m_ov = 1'b0; m_od = '0; m_oi = 0;
        obs_idx.delete(); obs_data.delete(); obs_cyc.delete();
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rand_mode && src_left[i] == 0 && $urandom_range(99) < 30) begin
                src_left[i] = $urandom_range(1, 7);
            end
            in_valid[i] = (src_delay[i] == 0) && (src_left[i] > 0);
            in_data[i]  = src_data[i];
        end
        if (rand_mode) begin
            out_ready = ($urandom_range(99) < 70);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_comb();
        c_owner = m_owner;
        c_start = m_ptr;
        c_beats = m_beats;
        if (c_owner >= 0 && !in_valid[c_owner]) begin
            c_start = (c_owner + 1) % N;
            c_owner = -1;
            c_beats = 0;
        end
        e_sel = -1;
        if (c_owner >= 0) begin
            e_sel = c_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (e_sel < 0 && in_valid[(c_start + k) % N]) e_sel = (c_start + k) % N;
            end
        end
        e_hs = (!m_ov || out_ready) && (e_sel >= 0);
        e_ready = '0;
        if (e_hs) e_ready[e_sel] = 1'b1;
    endtask

    task automatic model_update();
        bit any_hs;
        m_ptr = c_start;
        m_owner = c_owner;
        m_beats = c_beats;
        if (e_hs) begin
            m_ov = 1'b1;
            m_od = in_data[e_sel];
            m_oi = e_sel;
            m_beats++;
            if (m_beats == MB) begin
                m_owner = -1;
                m_beats = 0;
                m_ptr = (e_sel + 1) % N;
            end else begin
                m_owner = e_sel;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        // Drivers, scoreboard and fairness follow the handshakes the DUT made.
        any_hs = |(s_ready & in_valid);
        for (int i = 0; i < N; i++) begin
            if (s_ready[i] && in_valid[i]) begin
                exp_q[i].push_back(in_data[i]);
                src_left[i]--;
                src_data[i] = src_data[i] + 1'b1;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                wait_cnt[i] = 0;
            end else if (in_valid[i]) begin
                if (any_hs) wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
            if (src_delay[i] > 0) src_delay[i]--;
        end
    endtask

    task automatic observe();
        int idx;
        idx = int'(out_idx);
        obs_idx.push_back(idx);
        obs_data.push_back(out_data);
        obs_cyc.push_back(cyc);
        if (idx >= N) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_idx: got index %0d, must be below %0d", idx, N);
        end else if (exp_q[idx].size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_extra: idx %0d data %0h, required no beat", idx, out_data);
        end else begin
            chk("sb_order", 32'(out_data), 32'(exp_q[idx].pop_front()));
        end
    endtask

    // One clock: drive at negedge, compare 1 time unit later, update at posedge.
    task automatic cycle();
        drive_inputs();
        #1;
        model_comb();
        s_ready = in_ready;
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_idx", 32'(out_idx), 32'(m_oi));
        end
        chk("rr_ptr", 32'(dut.r_rr), 32'(m_ptr));
        if (bp_check) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h401);
            chk("bp_idx", 32'(out_idx), 32'd0);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) observe();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int start;
        bit done;
        max_wait = 0;
        do_reset();

        // Reset state.
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rr", 32'(dut.r_rr), 32'd0);
        @(negedge clk);

        // Single requester: 10 beats from requester 2 at full rate.
        src_data[2] = 16'h100;
        src_left[2] = 10;
        start = cyc;
        repeat (12) cycle();
        chk("t1_count", 32'(obs_idx.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < obs_idx.size()) begin
                chk("t1_idx", 32'(obs_idx[k]), 32'd2);
                chk("t1_data", 32'(obs_data[k]), 32'h100 + 32'(k));
                chk("t1_cyc", 32'(obs_cyc[k]), 32'(start + 1 + k));
            end
        end
        // 2 -> wraps to 0 for three requesters.
        chk("t1_rr", 32'(dut.r_rr), 32'd0);

        // Burst fairness between requesters 0 and 1.
        do_reset();
        src_left[0] = 100;
        src_left[1] = 100;
        repeat (14) cycle();
        chk("t2_count", 32'(obs_idx.size() >= 12), 32'd1);
        for (int k = 0; k < 12; k++) begin
            if (k < obs_idx.size()) begin
                chk("t2_idx", 32'(obs_idx[k]), 32'(t2_exp[k]));
                chk("t2_gap", 32'(obs_cyc[k] - obs_cyc[0]), 32'(k));
            end
        end

        // Early release: top requester sends 2 beats, then requester 0 takes over.
        do_reset();
        src_data[2] = 16'h300; src_left[2] = 2;
        src_data[0] = 16'h0a0; src_left[0] = 2; src_delay[0] = 1;
        repeat (3) cycle();
        chk("t3_rr_wrap", 32'(dut.r_rr), 32'd0);
        repeat (3) cycle();
        chk("t3_rr_end", 32'(dut.r_rr), 32'd1);
        chk("t3_count", 32'(obs_idx.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_idx.size()) begin
                chk("t3_idx", 32'(obs_idx[k]), (k < 2) ? 32'd2 : 32'd0);
                chk("t3_gap", 32'(obs_cyc[k] - obs_cyc[0]), 32'(k));
            end
        end

        // Backpressure: stall for 5 cycles mid-burst of requester 0.
        do_reset();
        src_data[0] = 16'h400; src_left[0] = 6;
        src_data[1] = 16'h500; src_left[1] = 4;
        for (int k = 0; k < 17; k++) begin
            out_ready = (k < 2) || (k > 6);
            bp_check = (k >= 2) && (k <= 6);
            cycle();
        end
        bp_check = 1'b0;
        chk("t4_count", 32'(obs_idx.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < obs_idx.size()) begin
                chk("t4_idx", 32'(obs_idx[k]), 32'(t4_idx[k]));
                chk("t4_data", 32'(obs_data[k]), 32'(t4_dat[k]));
            end
        end

        // Reset mid-burst with a beat held.
        do_reset();
        src_data[1] = 16'h600; src_left[1] = 6;
        out_ready = 1'b1;
        cycle();
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("t5_held", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_data", 32'(out_data), 32'd0);
        in_valid = '0;
        clear_bench();
        @(negedge clk);
        @(negedge clk);
        src_data[0] = 16'hb00; src_left[0] = 2;
        src_data[2] = 16'hb20; src_left[2] = 2;
        out_ready = 1'b1;
        rst = 1'b0;
        repeat (6) cycle();
        chk("t5_count", 32'(obs_idx.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_idx.size()) chk("t5_idx", 32'(obs_idx[k]), 32'(t5_idx[k]));
        end
        if (obs_data.size() > 0) chk("t5_first_data", 32'(obs_data[0]), 32'hb00);

        // Randomized traffic with random backpressure.
        do_reset();
        max_wait = 0;
        rand_mode = 1'b1;
        repeat (1500) cycle();
        rand_mode = 1'b0;
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            cycle();
            done = !m_ov;
            for (int i = 0; i < N; i++) if (src_left[i] != 0) done = 1'b0;
        end
        chk("drain_done", 32'(done), 32'd1);
        for (int i = 0; i < N; i++) chk("sb_leftover", 32'(exp_q[i].size()), 32'd0);
        chk("fair_bound", 32'(max_wait <= (N - 1) * MB), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
